// File: rtl/fp_issue_ctrl_if.sv
// Issue-stage <-> FPU handshake bundle.
//   master : the issue stage (drives request payload and out_ready)
//   slave  : the FPU top (drives in_ready, result valid, result, status)
// Request : in_valid/in_ready, operands (slot k at [k*FLEN +: FLEN]),
//           rnd_mode, op, op_mod, src_fmt, dst_fmt
// Response: out_valid/out_ready, result, status {NV,DZ,OF,UF,NX}
interface fp_issue_ctrl_if #(
    parameter int FLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [3*FLEN-1:0]   operands;
    logic [2:0]          rnd_mode;
    logic [3:0]          op;
    logic                op_mod;
    logic [2:0]          src_fmt;
    logic [2:0]          dst_fmt;
    logic                out_valid;
    logic                out_ready;
    logic [FLEN-1:0]     result;
    logic [4:0]          status;

    modport master (
        output in_valid, operands, rnd_mode, op, op_mod, src_fmt, dst_fmt, out_ready,
        input  in_ready, out_valid, result, status
    );

    modport slave (
        input  in_valid, operands, rnd_mode, op, op_mod, src_fmt, dst_fmt, out_ready,
        output in_ready, out_valid, result, status
    );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FP issue/writeback stage between the FP decoder and
// the FPU. Captures one decoded instruction and its operands, resolves the
// rounding mode, issues to the FPU, retires the result to the FP or integer
// register file and accumulates sticky fflags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kill the in-flight instruction
//   dec_*, illegal_insn, fp_*      decoded instruction from the decoder
//   fp_rf_raddr_a/b/c   rs1/rs2/rs3, passed through on rf_raddr_a/b/c
//   rf_rdata_a/b/c      asynchronous FP register file read data
//   fpu                 FPU request/response bundle (master side)
//   fp_we/waddr/wdata   FP register file write port
//   int_we/waddr/wdata  integer register file write port (low result bits)
//   fflags, fflags_clr  sticky exception flags and their clear
//   illegal             one-cycle pulse after a rejected instruction
//
// Build option: define FP_ISSUE_OVERLAP_EN to accept a new instruction in
// the writeback cycle, with rd->rs forwarding from the FP write port.
//
// state | meaning
// IDLE  | waiting for a decoded instruction
// ISSUE | request presented to the FPU, waiting for in_ready
// WAIT  | request taken, waiting for the FPU result
// WB    | one-cycle register file writeback and fflags update
module fp_issue_ctrl #(
    parameter int FLEN         = 32,
    parameter int INT_WB_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic                    illegal_insn,
    input  logic [2:0]              fp_rounding_mode,
    input  logic                    fp_rm_dynamic,
    input  logic [2:0]              frm,
    input  logic [3:0]              fp_alu_operator,
    input  logic                    fp_alu_op_mod,
    input  logic [2:0]              fp_src_fmt,
    input  logic [2:0]              fp_dst_fmt,
    input  logic [4:0]              fp_rf_raddr_a,
    input  logic [4:0]              fp_rf_raddr_b,
    input  logic [4:0]              fp_rf_raddr_c,
    input  logic [4:0]              fp_rf_waddr,
    output logic [4:0]              rf_raddr_a,
    output logic [4:0]              rf_raddr_b,
    output logic [4:0]              rf_raddr_c,
    input  logic [FLEN-1:0]         rf_rdata_a,
    input  logic [FLEN-1:0]         rf_rdata_b,
    input  logic [FLEN-1:0]         rf_rdata_c,
    fp_issue_ctrl_if.master         fpu,
    output logic                    fp_we,
    output logic [4:0]              fp_waddr,
    output logic [FLEN-1:0]         fp_wdata,
    output logic                    int_we,
    output logic [4:0]              int_waddr,
    output logic [INT_WB_WIDTH-1:0] int_wdata,
    output logic [4:0]              fflags,
    input  logic                    fflags_clr,
    output logic                    illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    // fpnew operation_e encodings that matter here
    localparam logic [3:0] OP_ADD      = 4'd2;
    localparam logic [3:0] OP_CMP      = 4'd8;
    localparam logic [3:0] OP_CLASSIFY = 4'd9;
    localparam logic [3:0] OP_F2I      = 4'd11;

    logic [1:0]         state;
    logic [3:0]         op_q;
    logic               mod_q;
    logic [2:0]         src_fmt_q;
    logic [2:0]         dst_fmt_q;
    logic [2:0]         rm_q;
    logic [4:0]         rd_q;
    logic [3*FLEN-1:0]  operands_q;
    logic               killed_q;
    logic [FLEN-1:0]    result_q;
    logic [4:0]         status_q;
    logic [4:0]         fflags_q;
    logic               illegal_q;

    logic [2:0]         rm_eff;
    logic               rm_bad;
    logic               accept;
    logic               reject;
    logic               capture;
    logic               is_int_op;
    logic               wb_live;
    logic [FLEN-1:0]    src_a;
    logic [FLEN-1:0]    src_b;
    logic [FLEN-1:0]    src_c;

    assign rf_raddr_a = fp_rf_raddr_a;
    assign rf_raddr_b = fp_rf_raddr_b;
    assign rf_raddr_c = fp_rf_raddr_c;

    assign rm_eff = fp_rm_dynamic ? frm : fp_rounding_mode;
    // 101/110 are reserved and 111 (DYN) is never a legal resolved mode
    assign rm_bad = (rm_eff >= 3'd5);

`ifdef FP_ISSUE_OVERLAP_EN
    assign dec_ready = ~flush & ((state == S_IDLE) | (state == S_WB));
`else
    assign dec_ready = ~flush & (state == S_IDLE);
`endif

    assign accept  = dec_valid & dec_ready;
    assign reject  = accept & (illegal_insn | rm_bad);
    assign capture = accept & ~reject;

    assign is_int_op = (op_q == OP_CMP) | (op_q == OP_CLASSIFY) | (op_q == OP_F2I);
    assign wb_live   = (state == S_WB) & ~killed_q;

    assign fp_we     = wb_live & ~is_int_op;
    assign fp_waddr  = rd_q;
    assign fp_wdata  = result_q;
    assign int_we    = wb_live & is_int_op;
    assign int_waddr = rd_q;
    assign int_wdata = result_q[INT_WB_WIDTH-1:0];

`ifdef FP_ISSUE_OVERLAP_EN
    // An instruction accepted during WB must see the value being written now,
    // since the register file only updates at the end of this cycle.
    always_comb begin
        src_a = rf_rdata_a;
        src_b = rf_rdata_b;
        src_c = rf_rdata_c;
        if (fp_we && (fp_waddr == fp_rf_raddr_a)) src_a = fp_wdata;
        if (fp_we && (fp_waddr == fp_rf_raddr_b)) src_b = fp_wdata;
        if (fp_we && (fp_waddr == fp_rf_raddr_c)) src_c = fp_wdata;
    end
`else
    assign src_a = rf_rdata_a;
    assign src_b = rf_rdata_b;
    assign src_c = rf_rdata_c;
`endif

    assign fpu.in_valid  = (state == S_ISSUE);
    assign fpu.operands  = operands_q;
    assign fpu.rnd_mode  = rm_q;
    assign fpu.op        = op_q;
    assign fpu.op_mod    = mod_q;
    assign fpu.src_fmt   = src_fmt_q;
    assign fpu.dst_fmt   = dst_fmt_q;
    assign fpu.out_ready = (state == S_WAIT);

    assign fflags  = fflags_q;
    assign illegal = illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            mod_q      <= 1'b0;
            src_fmt_q  <= '0;
            dst_fmt_q  <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            operands_q <= '0;
            killed_q   <= 1'b0;
            result_q   <= '0;
            status_q   <= '0;
            fflags_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q <= reject;
            // a clear in the WB cycle must not lose that instruction's flags
            fflags_q  <= (fflags_clr ? 5'd0 : fflags_q) | (wb_live ? status_q : 5'd0);

            if (capture) begin
                op_q      <= fp_alu_operator;
                mod_q     <= fp_alu_op_mod;
                src_fmt_q <= fp_src_fmt;
                dst_fmt_q <= fp_dst_fmt;
                rm_q      <= rm_eff;
                rd_q      <= fp_rf_waddr;
                // fpnew ADD reads its addends from slots 1 and 2
                if (fp_alu_operator == OP_ADD)
                    operands_q <= {src_b, src_a, {FLEN{1'b0}}};
                else
                    operands_q <= {src_c, src_b, src_a};
            end

            case (state)
                S_IDLE: begin
                    if (capture) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (fpu.in_ready) begin
                        state    <= S_WAIT;
                        killed_q <= flush;
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (flush) killed_q <= 1'b1;
                    if (fpu.out_valid) begin
                        result_q <= fpu.result;
                        status_q <= fpu.status;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    killed_q <= 1'b0;
                    state    <= capture ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
module tb_fp_issue_ctrl;

    localparam int FLEN = 32;
`ifdef FP_ISSUE_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, dec_valid, dec_ready, illegal_insn;
    logic [2:0] fp_rounding_mode, frm, fp_src_fmt, fp_dst_fmt;
    logic fp_rm_dynamic, fp_alu_op_mod;
    logic [3:0] fp_alu_operator;
    logic [4:0] fp_rf_raddr_a, fp_rf_raddr_b, fp_rf_raddr_c, fp_rf_waddr;
    logic [4:0] rf_raddr_a, rf_raddr_b, rf_raddr_c;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
    logic fp_we, int_we, fflags_clr, illegal;
    logic [4:0] fp_waddr, int_waddr, fflags;
    logic [31:0] fp_wdata, int_wdata;

    fp_issue_ctrl_if #(.FLEN(FLEN)) fpu ();

    fp_issue_ctrl #(.FLEN(FLEN), .INT_WB_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .illegal_insn(illegal_insn),
        .fp_rounding_mode(fp_rounding_mode), .fp_rm_dynamic(fp_rm_dynamic), .frm(frm),
        .fp_alu_operator(fp_alu_operator), .fp_alu_op_mod(fp_alu_op_mod),
        .fp_src_fmt(fp_src_fmt), .fp_dst_fmt(fp_dst_fmt),
        .fp_rf_raddr_a(fp_rf_raddr_a), .fp_rf_raddr_b(fp_rf_raddr_b), .fp_rf_raddr_c(fp_rf_raddr_c),
        .fp_rf_waddr(fp_rf_waddr),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_c(rf_raddr_c),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_c(rf_rdata_c),
        .fpu(fpu),
        .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
        .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata),
        .fflags(fflags), .fflags_clr(fflags_clr), .illegal(illegal)
    );

    int errors = 0;
    int checks = 0;
    int issues = 0;
    int ill_cnt = 0;

    // expected per-cycle behaviour, set by the stimulus before each cycle
    logic exp_ready, exp_inv, exp_outr, exp_fpwe, exp_intwe, exp_ill;
    logic [95:0] exp_ops;
    logic [3:0] exp_op;
    logic exp_mod;
    logic [2:0] exp_rm, exp_sf, exp_df;
    logic [4:0] exp_wa, cur_status, fflags_m;
    logic [31:0] exp_wd;
    logic chk_en = 1'b0;
    logic rand_clr = 1'b0;
    logic [95:0] last_ops;
    logic [31:0] last_fp_wd, last_int_wd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dec_ready", dec_ready, exp_ready);
            chk("in_valid", fpu.in_valid, exp_inv);
            chk("out_ready", fpu.out_ready, exp_outr);
            chk("fp_we", fp_we, exp_fpwe);
            chk("int_we", int_we, exp_intwe);
            chk("illegal", illegal, exp_ill);
            chk("fflags", fflags, fflags_m);
            chk("raddr_a", rf_raddr_a, fp_rf_raddr_a);
            chk("raddr_c", rf_raddr_c, fp_rf_raddr_c);
            if (exp_inv) begin
                chk("operands", fpu.operands, exp_ops);
                chk("rnd_mode", fpu.rnd_mode, exp_rm);
                chk("op", fpu.op, exp_op);
                chk("op_mod", fpu.op_mod, exp_mod);
                chk("src_fmt", fpu.src_fmt, exp_sf);
                chk("dst_fmt", fpu.dst_fmt, exp_df);
            end
            if (exp_fpwe) begin
                chk("fp_waddr", fp_waddr, exp_wa);
                chk("fp_wdata", fp_wdata, exp_wd);
            end
            if (exp_intwe) begin
                chk("int_waddr", int_waddr, exp_wa);
                chk("int_wdata", int_wdata, exp_wd);
            end
        end
        if (fpu.in_valid) last_ops = fpu.operands;
        if (fpu.in_valid && fpu.in_ready) issues++;
        if (fp_we) last_fp_wd = fp_wdata;
        if (int_we) last_int_wd = int_wdata;
        if (illegal) ill_cnt++;
    end

    task automatic set_exp(input logic r, input logic iv, input logic orr,
                           input logic fw, input logic iw, input logic il);
        exp_ready = r; exp_inv = iv; exp_outr = orr;
        exp_fpwe = fw; exp_intwe = iw; exp_ill = il;
    endtask

    // advance one clock; the fflags model follows the sticky-OR rule
    task automatic cyc();
        @(posedge clk);
        if (rst) fflags_m = 5'd0;
        else fflags_m = (fflags_clr ? 5'd0 : fflags_m) | ((exp_fpwe | exp_intwe) ? cur_status : 5'd0);
        #1;
        fflags_clr = rand_clr && ($urandom_range(0, 5) == 0);
    endtask

    task automatic scramble_dec();
        fp_alu_operator = 4'($urandom); fp_alu_op_mod = 1'($urandom);
        fp_rf_raddr_a = 5'($urandom); fp_rf_raddr_b = 5'($urandom); fp_rf_raddr_c = 5'($urandom);
        fp_rf_waddr = 5'($urandom);
        rf_rdata_a = $urandom; rf_rdata_b = $urandom; rf_rdata_c = $urandom;
        fp_rounding_mode = 3'($urandom); frm = 3'($urandom); fp_rm_dynamic = 1'($urandom);
        illegal_insn = 1'($urandom); fp_src_fmt = 3'($urandom); fp_dst_fmt = 3'($urandom);
    endtask

    // fmode: 0 none, 1 flush in ISSUE at wait cycle fpos (< rdly),
    //        2 flush on the handshake cycle, 3 flush in WAIT at cycle fpos
    task automatic do_insn(input logic [3:0] op, input logic md, input logic [2:0] sf, input logic [2:0] df,
                           input logic dyn, input logic [2:0] rm, input logic [2:0] fr, input logic ill,
                           input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                           input logic [31:0] da, input logic [31:0] db, input logic [31:0] dc,
                           input int rdly, input int lat, input logic [31:0] res, input logic [4:0] st,
                           input int fmode, input int fpos, input logic clr_wb);
        logic [2:0] eff;
        logic killed, int_op;
        eff = dyn ? fr : rm;
        fp_alu_operator = op; fp_alu_op_mod = md; fp_src_fmt = sf; fp_dst_fmt = df;
        fp_rm_dynamic = dyn; fp_rounding_mode = rm; frm = fr; illegal_insn = ill;
        fp_rf_waddr = rd; fp_rf_raddr_a = ra; fp_rf_raddr_b = rb; fp_rf_raddr_c = rc;
        rf_rdata_a = da; rf_rdata_b = db; rf_rdata_c = dc;
        dec_valid = 1'b1; flush = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0);
        cyc();
        dec_valid = 1'b0;
        scramble_dec();
        if (ill || eff >= 3'd5) begin
            set_exp(1, 0, 0, 0, 0, 1);
            cyc();
            return;
        end
        exp_op = op; exp_mod = md; exp_sf = sf; exp_df = df; exp_rm = eff;
        exp_ops = (op == 4'd2) ? {db, da, 32'h0} : {dc, db, da};
        for (int k = 0; k <= rdly; k++) begin
            fpu.in_ready = (k == rdly);
            flush = (fmode == 1 && k == fpos) || (fmode == 2 && k == rdly);
            dec_valid = 1'($urandom);
            set_exp(0, 1, 0, 0, 0, 0);
            cyc();
            if (fmode == 1 && k == fpos) begin
                fpu.in_ready = 1'b0; flush = 1'b0; dec_valid = 1'b0;
                set_exp(1, 0, 0, 0, 0, 0);
                cyc();
                return;
            end
        end
        fpu.in_ready = 1'b0;
        killed = (fmode == 2);
        for (int j = 0; j <= lat; j++) begin
            fpu.out_valid = (j == lat);
            fpu.result = (j == lat) ? res : $urandom;
            fpu.status = (j == lat) ? st : 5'($urandom);
            flush = (fmode == 3 && j == fpos);
            if (flush) killed = 1'b1;
            dec_valid = 1'($urandom);
            set_exp(0, 0, 1, 0, 0, 0);
            cyc();
        end
        fpu.out_valid = 1'b0; fpu.result = $urandom; fpu.status = 5'($urandom);
        flush = 1'b0; dec_valid = 1'b0;
        int_op = (op == 4'd8) || (op == 4'd9) || (op == 4'd11);
        cur_status = st; exp_wa = rd; exp_wd = res;
        if (clr_wb) fflags_clr = 1'b1;
        set_exp(OVL, 0, 0, ~killed & ~int_op, ~killed & int_op, 0);
        cyc();
    endtask

    int n_iss, n_ill;

    initial begin
        rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; fflags_clr = 1'b0;
        scramble_dec();
        fpu.in_ready = 1'b0; fpu.out_valid = 1'b0; fpu.result = '0; fpu.status = '0;
        fflags_m = 5'd0; cur_status = 5'd0;
        exp_ops = '0; exp_op = '0; exp_mod = 1'b0; exp_rm = '0; exp_sf = '0; exp_df = '0;
        exp_wa = '0; exp_wd = '0;
        last_ops = '0; last_fp_wd = '0; last_int_wd = '0;
        set_exp(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk("rst_operands", fpu.operands, 96'h0);
        chk("rst_fp_wdata", fp_wdata, 32'h0);
        chk("rst_int_wdata", int_wdata, 32'h0);
        chk("rst_rnd_op", {fpu.rnd_mode, fpu.op, fp_waddr}, 12'h0);
        cyc();
        rst = 1'b0;

        // FADD.S 1.0 + 2.0
        do_insn(4'd2, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 5'd7, 5'd1, 5'd2, 5'd3,
                32'h3F800000, 32'h40000000, 32'h12345678, 0, 1, 32'h40400000, 5'd0, 0, 0, 0);
        chk("fadd_slots", last_ops, 96'h40000000_3F800000_00000000);
        chk("fadd_wdata", last_fp_wd, 32'h40400000);

        // in_ready held low for 5 cycles
        n_iss = issues;
        do_insn(4'd3, 1, 3'd1, 3'd2, 0, 3'd3, 3'd0, 0, 5'd9, 5'd4, 5'd5, 5'd6,
                32'h11111111, 32'h22222222, 32'h33333333, 5, 0, 32'h44444444, 5'd0, 0, 0, 0);
        chk("one_issue", issues - n_iss, 1);

        // dynamic rm resolving to 101 is rejected
        n_iss = issues; n_ill = ill_cnt;
        do_insn(4'd3, 0, 3'd0, 3'd0, 1, 3'd0, 3'd5, 0, 5'd1, 5'd1, 5'd1, 5'd1,
                32'h1, 32'h2, 32'h3, 0, 0, 32'h0, 5'd0, 0, 0, 0);
        chk("rej_no_issue", issues - n_iss, 0);
        chk("rej_one_pulse", ill_cnt - n_ill, 1);

        // reset while waiting for the FPU abandons the instruction
        fp_alu_operator = 4'd3; fp_alu_op_mod = 0; fp_src_fmt = 0; fp_dst_fmt = 0;
        fp_rm_dynamic = 0; fp_rounding_mode = 3'd1; illegal_insn = 0; fp_rf_waddr = 5'd2;
        rf_rdata_a = 32'hA; rf_rdata_b = 32'hB; rf_rdata_c = 32'hC;
        exp_op = 4'd3; exp_mod = 0; exp_sf = 0; exp_df = 0; exp_rm = 3'd1;
        exp_ops = {32'hC, 32'hB, 32'hA};
        dec_valid = 1; set_exp(1, 0, 0, 0, 0, 0); cyc(); dec_valid = 0;
        fpu.in_ready = 1; set_exp(0, 1, 0, 0, 0, 0); cyc(); fpu.in_ready = 0;
        rst = 1; set_exp(0, 0, 1, 0, 0, 0); cyc(); rst = 0;
        set_exp(1, 0, 0, 0, 0, 0); cyc();

        // FEQ.S -> integer writeback, NV
        do_insn(4'd8, 0, 3'd0, 3'd0, 0, 3'd2, 3'd0, 0, 5'd10, 5'd1, 5'd2, 5'd3,
                32'h3F800000, 32'h3F800000, 32'h0, 0, 2, 32'h1, 5'h10, 0, 0, 0);
        chk("feq_int_wdata", last_int_wd, 32'h1);
        chk("feq_fflags", fflags, 5'h10);
        do_insn(4'd4, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 5'd11, 5'd1, 5'd2, 5'd3,
                32'h3F800000, 32'h0, 32'h0, 1, 1, 32'h7F800000, 5'h08, 0, 0, 0);
        chk("fdiv_fflags", fflags, 5'h18);
        do_insn(4'd4, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 5'd12, 5'd1, 5'd2, 5'd3,
                32'h3F800000, 32'h0, 32'h0, 0, 0, 32'h7F800000, 5'h08, 0, 0, 1);
        chk("clr_in_wb_fflags", fflags, 5'h08);
        // flush in WAIT: result drained, nothing retired, NX dropped
        do_insn(4'd3, 0, 3'd0, 3'd0, 0, 3'd0, 3'd0, 0, 5'd13, 5'd1, 5'd2, 5'd3,
                32'h1, 32'h2, 32'h3, 0, 2, 32'h5, 5'h01, 3, 0, 0);
        chk("flush_wait_fflags", fflags, 5'h08);

`ifdef FP_ISSUE_OVERLAP_EN
        // FMUL f3 <- 8.0 in WB while an FADD reading f3 is accepted
        fp_alu_operator = 4'd3; fp_rm_dynamic = 0; fp_rounding_mode = 0; illegal_insn = 0;
        fp_alu_op_mod = 0; fp_src_fmt = 0; fp_dst_fmt = 0; fp_rf_waddr = 5'd3;
        fp_rf_raddr_a = 5'd1; fp_rf_raddr_b = 5'd2; fp_rf_raddr_c = 5'd0;
        rf_rdata_a = 32'h40000000; rf_rdata_b = 32'h40800000; rf_rdata_c = 32'h0;
        exp_op = 4'd3; exp_mod = 0; exp_sf = 0; exp_df = 0; exp_rm = 0;
        exp_ops = {32'h0, 32'h40800000, 32'h40000000};
        dec_valid = 1; set_exp(1, 0, 0, 0, 0, 0); cyc(); dec_valid = 0;
        fpu.in_ready = 1; set_exp(0, 1, 0, 0, 0, 0); cyc(); fpu.in_ready = 0;
        fpu.out_valid = 1; fpu.result = 32'h41000000; fpu.status = 0;
        set_exp(0, 0, 1, 0, 0, 0); cyc(); fpu.out_valid = 0;
        exp_wa = 5'd3; exp_wd = 32'h41000000; cur_status = 0;
        fp_alu_operator = 4'd2; fp_rf_waddr = 5'd6; fp_rf_raddr_a = 5'd3; fp_rf_raddr_b = 5'd4;
        rf_rdata_a = 32'hDEADBEEF; rf_rdata_b = 32'h3F800000;
        dec_valid = 1; set_exp(1, 0, 0, 1, 0, 0); cyc(); dec_valid = 0;
        exp_op = 4'd2; exp_ops = {32'h3F800000, 32'h41000000, 32'h0};
        fpu.in_ready = 1; set_exp(0, 1, 0, 0, 0, 0); cyc(); fpu.in_ready = 0;
        chk("ovl_fwd_slot1", last_ops, 96'h3F800000_41000000_00000000);
        fpu.out_valid = 1; fpu.result = 32'h41100000; fpu.status = 0;
        set_exp(0, 0, 1, 0, 0, 0); cyc(); fpu.out_valid = 0;
        exp_wa = 5'd6; exp_wd = 32'h41100000;
        set_exp(1, 0, 0, 1, 0, 0); cyc();
`endif

        // randomized traffic against the model
        rand_clr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int rdly, lat, fmode, fpos, r;
            rdly = $urandom_range(0, 3);
            lat = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            fmode = 0; fpos = 0;
            if (r == 6 && rdly > 0) begin fmode = 1; fpos = $urandom_range(0, rdly - 1); end
            else if (r == 7) fmode = 2;
            else if (r >= 8) begin fmode = 3; fpos = $urandom_range(0, lat); end
            if ($urandom_range(0, 7) == 0) begin
                flush = 1; dec_valid = 1;
                set_exp(0, 0, 0, 0, 0, 0); cyc();
                flush = 0; dec_valid = 0;
            end
            do_insn(4'($urandom_range(0, 14)), 1'($urandom), 3'($urandom), 3'($urandom),
                    1'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    $urandom, $urandom, $urandom, rdly, lat, $urandom, 5'($urandom),
                    fmode, fpos, 0);
        end
        rand_clr = 1'b0;
        fflags_clr = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0);
        cyc();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Single-outstanding FP issue/writeback stage, directly downstream of the FP instruction decoder.
- Accepts one decoded FP instruction and captures its operands from the FP register file.
- Resolves the rounding mode and issues the operation to the fpnew FPU top over a valid/ready handshake.
- Retires the result to the FP or integer register file and accumulates sticky fflags for the FCSR.

Parameters:
- FLEN, 32: operand/result width in bits.
- INT_WB_WIDTH, 32: integer writeback width; the low bits of the result are taken.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, synchronous, active-high.
- flush_i in 1: kill the in-flight instruction.
- dec_valid_i in 1: decoded instruction valid.
- dec_ready_o out 1: stage can accept an instruction.
- illegal_insn_i in 1: decoder illegal flag.
- fp_rounding_mode_i in 3: static rm field.
- fp_rm_dynamic_i in 1: rm=111, use frm_i.
- frm_i in 3: FCSR.frm.
- fp_alu_operator_i in 4: fpnew operation_e.
- fp_alu_op_mod_i in 1: op modifier.
- fp_src_fmt_i, fp_dst_fmt_i in 3 each: fp_format_e.
- fp_rf_raddr_a_i, fp_rf_raddr_b_i, fp_rf_raddr_c_i in 5 each: rs1/rs2/rs3.
- fp_rf_waddr_i in 5: rd.
- rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o out 5 each: combinational pass-through of the read addresses.
- rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i in FLEN each: asynchronous read data.
- fpu_in_valid_o out 1; fpu_in_ready_i in 1.
- fpu_operands_o out 3*FLEN: slot k occupies bits [k*FLEN +: FLEN].
- fpu_rnd_mode_o out 3; fpu_op_o out 4; fpu_op_mod_o out 1.
- fpu_src_fmt_o, fpu_dst_fmt_o out 3 each.
- fpu_out_valid_i in 1; fpu_out_ready_o out 1.
- fpu_result_i in FLEN; fpu_status_i in 5: NV,DZ,OF,UF,NX.
- fp_we_o out 1; fp_waddr_o out 5; fp_wdata_o out FLEN.
- int_we_o out 1; int_waddr_o out 5; int_wdata_o out INT_WB_WIDTH.
- fflags_o out 5: sticky accumulated flags.
- fflags_clr_i in 1: clear fflags.
- illegal_o out 1: one-cycle pulse on a rejected instruction.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, except dec_ready_o=1.
  - The captured-instruction register is cleared.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - dec_ready_o = ~flush_i.
  - An accept happens when dec_valid_i & dec_ready_o.
  - Effective rm = fp_rm_dynamic_i ? frm_i : fp_rounding_mode_i.
  - Reject if illegal_insn_i is set or the effective rm is 101/110/111. On reject: illegal_o=1 next cycle, nothing captured, stay in IDLE.
  - Otherwise capture op, mod, formats, rm, rd and the three rf_rdata values in the accept cycle, then go to ISSUE.
- Operand slot mapping:
  - ADD (covers FADD and FSUB): slot0=0, slot1=rs1, slot2=rs2.
  - All other operations: slot0=rs1, slot1=rs2, slot2=rs3.
- ISSUE:
  - fpu_in_valid_o=1.
  - All fpu_* payload outputs are held stable until fpu_in_ready_i.
  - On the handshake, go to WAIT.
  - flush_i before the handshake: drop the instruction and go to IDLE, with valid deasserted next cycle.
  - flush_i in the same cycle as the handshake: go to WAIT with the killed bit set.
- WAIT:
  - fpu_out_ready_o=1.
  - On fpu_out_valid_i, latch fpu_result_i and fpu_status_i, then go to WB.
  - flush_i in WAIT sets the killed bit. The result is still drained, but both writeback and fflags are suppressed.
- WB (exactly 1 cycle):
  - If not killed and the op is CMP, CLASSIFY or F2I: int_we_o=1, int_waddr_o=rd, int_wdata_o=result[INT_WB_WIDTH-1:0].
  - If not killed and any other op: fp_we_o=1, fp_waddr_o=rd, fp_wdata_o=result.
  - Then go to IDLE and clear the killed bit.
- fflags:
  - fflags_next = (fflags_clr_i ? 0 : fflags_o) | (WB & ~killed ? status : 0).
  - When a clear and a WB occur in the same cycle, the WB flags survive.
- Latency: accept at cycle N, earliest fpu_in_valid_o at N+1, writeback one cycle after fpu_out_valid_i, next accept in the cycle after WB.
  - Minimum issue interval with a 1-cycle FPU: 4 cycles.
- rst_i mid-operation: abandons the in-flight instruction with no writeback. fpu_out_ready_o=0 after reset; the FPU must be reset together with this stage.

Optional Feature:
- Macro: FP_ISSUE_OVERLAP_EN.
- Defined:
  - dec_ready_o is also asserted in WB (gated by ~flush_i), so an accept can overlap the writeback cycle. The FSM goes WB->ISSUE on accept, WB->IDLE otherwise.
  - Any captured rs1/rs2/rs3 equal to the rd being written by fp_we_o in that cycle takes fp_wdata_o instead of rf_rdata (forwarding).
  - Minimum interval becomes 3 cycles.
- Undefined: dec_ready_o=0 outside IDLE and no forwarding logic exists.

Test Plan:
- FADD.S, rs1=0x3F800000, rs2=0x40000000, static rm=000, FPU returns 0x40400000 with status 0:
  - fpu_operands_o slot1=0x3F800000, slot2=0x40000000, slot0=0.
  - fp_we_o pulses with waddr=rd and wdata=0x40400000.
- fpu_in_ready_i held low for 5 cycles in ISSUE -> fpu_in_valid_o stays 1 and the payload is unchanged every cycle; exactly one issue occurs.
- fp_rm_dynamic_i=1 with frm_i=101 -> illegal_o pulses once, there is no fpu_in_valid_o, and dec_ready_o stays 1.
- FEQ.S with result 1 and status NV=1 (0x10):
  - int_we_o=1, int_wdata_o=1, fp_we_o=0, fflags_o=0x10.
  - A later FDIV with DZ (0x08) makes fflags_o=0x18.
  - fflags_clr_i asserted in that FDIV's WB cycle gives 0x08.
- flush_i in WAIT, then fpu_out_valid_i with status NX -> fpu_out_ready_o=1, no fp_we_o/int_we_o, fflags_o unchanged.
- FP_ISSUE_OVERLAP_EN: FMUL writing f3=0x41000000 is in WB while an FADD reading rs1=f3 is accepted -> FADD slot1=0x41000000, and the FADD issue begins the next cycle.
